// File: rtl/picture_pkg.sv
// Shared definitions for the picture transfer block.
// Contents:
//   P_WORDS_DEF    - default picture size in 32-bit words (352x288 bytes / 4)
//   P_OUT_BASE_DEF - default word address of the first accelerator result word
//   state_t        - controller state encoding
package picture_pkg;

    localparam int unsigned P_WORDS_DEF    = 25344;
    localparam int unsigned P_OUT_BASE_DEF = 25344;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ACC_START = 3'd2,
        S_ACC_WAIT  = 3'd3,
        S_RD_REQ    = 3'd4,
        S_RD_WAIT   = 3'd5,
        S_SEND      = 3'd6
    } state_t;

endpackage

// File: rtl/picture_transfer.sv
// Picture transfer controller.
// Receives a picture byte-by-byte from a UART receiver and packs the bytes
// little-endian into 32-bit words, which it writes to a single-port memory.
// It then starts an accelerator, waits for it to finish, reads the result
// words back and sends them out byte-by-byte to a UART transmitter.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-low reset
//   rx_data, rx_stb     - received byte, one-cycle valid pulse
//   tx_data, tx_stb     - byte to transmit, held until tx_ack
//   tx_ack              - one-cycle pulse: transmitter finished the byte
//   mem_en, mem_we      - memory access enable / write enable
//   mem_addr            - memory word address
//   mem_dataw           - memory write data
//   mem_datar           - memory read data (valid one cycle after a read)
//   acc_start           - one-cycle pulse starting the accelerator
//   acc_finish          - accelerator done (level)
//   busy                - high whenever the controller is not idle
//   rx_overrun          - sticky: a byte arrived while it could not be taken
//   dbg_state           - current controller state
//
// Transmit handshake: a byte is transferred on the rising edge where
// tx_stb=1 and tx_ack=1. tx_stb/tx_data stay constant until then; tx_stb
// drops for at least one cycle after every handshake. tx_ack is ignored
// while tx_stb=0.
module picture_transfer
    import picture_pkg::*;
#(
    parameter int unsigned P_WORDS    = P_WORDS_DEF,
    parameter int unsigned P_OUT_BASE = P_OUT_BASE_DEF,
    parameter int unsigned P_ADDR_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_stb,
    output logic [7:0]          tx_data,
    output logic                tx_stb,
    input  logic                tx_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [P_ADDR_W-1:0] mem_addr,
    output logic [31:0]         mem_dataw,
    input  logic [31:0]         mem_datar,
    output logic                acc_start,
    input  logic                acc_finish,
    output logic                busy,
    output logic                rx_overrun,
    output state_t              dbg_state
);

    localparam logic [P_ADDR_W-1:0] LAST_IDX = P_ADDR_W'(P_WORDS - 1);
    localparam logic [P_ADDR_W-1:0] OUT_BASE = P_ADDR_W'(P_OUT_BASE);
    localparam logic [P_ADDR_W-1:0] ONE      = P_ADDR_W'(1);

    state_t              state, state_n;
    logic [P_ADDR_W-1:0] idx, idx_n;          // word index (load and readback)
    logic [1:0]          byte_cnt, byte_cnt_n; // byte position within the word being loaded
    logic [1:0]          lane, lane_n;         // byte lane of the word being sent
    logic [23:0]         pack, pack_n;         // bytes 0..2 of the word being loaded
    logic [31:0]         word, word_n;         // result word being sent
    logic [7:0]          tx_data_n;
    logic                tx_stb_n;
    logic                mem_en_n, mem_we_n;
    logic [P_ADDR_W-1:0] mem_addr_n;
    logic [31:0]         mem_dataw_n;
    logic                acc_start_n;
    logic                rx_overrun_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            byte_cnt   <= '0;
            lane       <= '0;
            pack       <= '0;
            word       <= '0;
            tx_data    <= '0;
            tx_stb     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_dataw  <= '0;
            acc_start  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            byte_cnt   <= byte_cnt_n;
            lane       <= lane_n;
            pack       <= pack_n;
            word       <= word_n;
            tx_data    <= tx_data_n;
            tx_stb     <= tx_stb_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_dataw  <= mem_dataw_n;
            acc_start  <= acc_start_n;
            rx_overrun <= rx_overrun_n;
        end
    end

    // All outputs except busy are registered; the *_n values below are what
    // each register holds during the next cycle.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        byte_cnt_n   = byte_cnt;
        lane_n       = lane;
        pack_n       = pack;
        word_n       = word;
        tx_data_n    = tx_data;
        tx_stb_n     = 1'b0;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_dataw_n  = mem_dataw;
        acc_start_n  = 1'b0;
        rx_overrun_n = rx_overrun;

        case (state)
            S_IDLE: begin
                if (rx_stb) begin
                    pack_n     = {16'h0000, rx_data};
                    byte_cnt_n = 2'd1;
                    idx_n      = '0;
                    state_n    = S_LOAD;
                end
            end

            S_LOAD: begin
                if (mem_we && mem_addr == LAST_IDX) begin
                    // The last word is being written this cycle; the picture
                    // is complete, so any further byte is an overrun.
                    state_n     = S_ACC_START;
                    acc_start_n = 1'b1;
                    if (rx_stb) begin
                        rx_overrun_n = 1'b1;
                    end
                end else if (rx_stb) begin
                    if (byte_cnt == 2'd3) begin
                        mem_en_n    = 1'b1;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = idx;
                        mem_dataw_n = {rx_data, pack};
                        byte_cnt_n  = 2'd0;
                        // The last index is kept so the write address above
                        // identifies the final word.
                        if (idx != LAST_IDX) begin
                            idx_n = idx + ONE;
                        end
                    end else begin
                        case (byte_cnt)
                            2'd1:    pack_n[15:8]  = rx_data;
                            2'd2:    pack_n[23:16] = rx_data;
                            default: pack_n[7:0]   = rx_data;
                        endcase
                        byte_cnt_n = byte_cnt + 2'd1;
                    end
                end
            end

            S_ACC_START: begin
                state_n = S_ACC_WAIT;
            end

            S_ACC_WAIT: begin
                if (acc_finish) begin
                    idx_n   = '0;
                    state_n = S_RD_REQ;
                end
            end

            S_RD_REQ: begin
                state_n = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                word_n    = mem_datar;
                lane_n    = 2'd0;
                tx_data_n = mem_datar[7:0];
                tx_stb_n  = 1'b1;
                state_n   = S_SEND;
            end

            S_SEND: begin
                if (tx_stb) begin
                    if (tx_ack) begin
                        if (lane != 2'd3) begin
                            lane_n = lane + 2'd1;
                        end else if (idx != LAST_IDX) begin
                            idx_n   = idx + ONE;
                            state_n = S_RD_REQ;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        tx_stb_n = 1'b1;
                    end
                end else begin
                    // Gap cycle after a handshake: present the next lane.
                    tx_stb_n  = 1'b1;
                    tx_data_n = word[{lane, 3'b000} +: 8];
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (rx_stb && state != S_IDLE && state != S_LOAD) begin
            rx_overrun_n = 1'b1;
        end

        // The read strobe is registered, so it is raised on entry to S_RD_REQ.
        if (state_n == S_RD_REQ) begin
            mem_en_n   = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = OUT_BASE + idx_n;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
